// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and defaults for the URCPU fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_RESET = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] S_HOLD  = 3'd2;
    localparam logic [STATE_W-1:0] S_FLUSH = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT  = 3'd4;

    localparam int RESET_PC_DEFAULT = 0;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Purpose  : Output register plus one pending entry between imem and decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buf #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               load,
    input  logic               park,
    input  logic               ready,
    input  logic [INSTR_W-1:0] din,
    input  logic [ADDR_W-1:0]  din_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_valid;
    logic [INSTR_W-1:0] r_pend_instr;
    logic [ADDR_W-1:0]  r_pend_pc;
    logic               r_pend_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_valid      <= 1'b0;
            r_pend_instr <= '0;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            if (load) begin
                r_instr    <= din;
                r_instr_pc <= din_pc;
                r_valid    <= 1'b1;
            end else if (r_pend_valid && ready) begin
                r_instr      <= r_pend_instr;
                r_instr_pc   <= r_pend_pc;
                r_valid      <= 1'b1;
                r_pend_valid <= 1'b0;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            // park only happens while the output is stalled, so it never races a drain
            if (park) begin
                r_pend_instr <= din;
                r_pend_pc    <= din_pc;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : URCPU fetch stage - PC, imem req/ack master, decode handoff.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               r_req;
    logic               w_req_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_ack;
    logic               w_can_load;
    logic               w_load;
    logic               w_park;

    assign w_ack      = imem_ack && r_req;
    assign w_can_load = !instr_valid || instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_RESET: w_state_nxt = halt ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (w_ack) begin
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = !w_can_load ? S_HOLD : (halt ? S_HALT : S_FETCH);
                end else if (!r_req && halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HOLD:  if (instr_ready) w_state_nxt = halt ? S_HALT : S_FETCH;
            S_FLUSH: if (w_ack) w_state_nxt = halt ? S_HALT : S_FETCH;
            S_HALT:  if (!halt) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_RESET;
        endcase
        // an in-flight request must still be retired, so it goes through FLUSH
        if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = (r_req && !w_ack) ? S_FLUSH : (halt ? S_HALT : S_FETCH);
        end
    end

    always_comb begin
        w_req_nxt  = (w_state_nxt == S_FLUSH) ||
                     ((w_state_nxt == S_FETCH) && (r_state != S_RESET));
        w_addr_nxt = (w_state_nxt == S_FLUSH) ? r_addr : w_pc_nxt;
        w_load     = (r_state == S_FETCH) && w_ack && w_can_load && !redirect;
        w_park     = (r_state == S_FETCH) && w_ack && !w_can_load && !redirect;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= c_reset_pc;
            r_req  <= 1'b0;
            r_addr <= c_reset_pc;
        end else begin
            r_pc   <= w_pc_nxt;
            r_req  <= w_req_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect),
        .load        (w_load),
        .park        (w_park),
        .ready       (instr_ready),
        .din         (imem_rdata),
        .din_pc      (r_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign busy      = r_req;

endmodule
`default_nettype wire
